// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: merges ALU and LSU results onto the single register
// file write port. The ALU has priority and a fixed 1-cycle latency. LSU results
// are queued in a DEPTH-entry FIFO and drain whenever the ALU leaves the port idle.
// A 32-bit pending scoreboard tracks destinations that are issued but not yet written.
// rf_we/rf_wr/rf_wd come straight from posedge registers, so they are stable at
// the register file's negedge write.
// Optional feature macro: WB_BYPASS_EN adds combinational decode-forwarding
// ports (byp_rs1/2, byp_hit1/2, byp_data1/2) that compare against the write
// currently held in the output register.
// Handshake: an LSU result transfers on a posedge where lsu_valid && lsu_ready.
// lsu_ready is !full and does not depend on lsu_valid or on a same-cycle pop.

`ifndef REGWE_WRITE
`define REGWE_WRITE 1'b1
`endif

module reg_writeback_arbiter #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
`ifdef WB_BYPASS_EN
   input  logic [4:0]      byp_rs1,
   input  logic [4:0]      byp_rs2,
   output logic            byp_hit1,
   output logic            byp_hit2,
   output logic [XLEN-1:0] byp_data1,
   output logic [XLEN-1:0] byp_data2,
`endif
   output logic            rf_we,
   output logic [4:0]      rf_wr,
   output logic [XLEN-1:0] rf_wd,
   output logic [31:0]     pending
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
   localparam logic WE_ON  = `REGWE_WRITE;
   localparam logic WE_OFF = ~`REGWE_WRITE;

   logic [4:0]      fifo_rd   [DEPTH];
   logic [XLEN-1:0] fifo_data [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;

   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            alu_take;
   logic            load_en;
   logic [4:0]      load_rd;
   logic [XLEN-1:0] load_data;
   logic [31:0]     pending_next;

   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign lsu_ready = !full;

   // Arbitration: the ALU always wins; the FIFO head only moves when the ALU is idle.
   // Writes to x0 are swallowed here and never reach the FIFO or the port.
   always_comb begin
      alu_take  = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      load_en   = 1'b0;
      load_rd   = fifo_rd[rd_ptr];
      load_data = fifo_data[rd_ptr];
      if (!flush) begin
         alu_take = alu_valid && (alu_rd != 5'd0);
         push     = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
         pop      = !alu_take && !empty;
         load_en  = alu_take || pop;
         if (alu_take) begin
            load_rd   = alu_rd;
            load_data = alu_data;
         end
      end
   end

   // Scoreboard update: clear the bit being written back, then set the newly issued bit
   // so a same-cycle set/clear leaves the newer producer outstanding.
   always_comb begin
      pending_next = pending;
      if (load_en) begin
         pending_next[load_rd] = 1'b0;
      end
      if (!flush && iss_valid && (iss_rd != 5'd0)) begin
         pending_next[iss_rd] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   // FIFO storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= lsu_rd;
         fifo_data[wr_ptr] <= lsu_data;
      end
   end

   // FIFO pointers and occupancy; flush discards everything queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output register: loads the winning write, otherwise drops the enable and holds address/data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we <= WE_OFF;
         rf_wr <= 5'd0;
         rf_wd <= '0;
      end else if (load_en) begin
         rf_we <= WE_ON;
         rf_wr <= load_rd;
         rf_wd <= load_data;
      end else begin
         rf_we <= WE_OFF;
      end
   end

   // Pending scoreboard register; flush forgets all outstanding producers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else if (flush) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

`ifdef WB_BYPASS_EN
   // Forward the write held in the output register to decode ahead of the negedge commit.
   always_comb begin
      byp_hit1  = (rf_we == WE_ON) && (rf_wr == byp_rs1) && (byp_rs1 != 5'd0);
      byp_hit2  = (rf_we == WE_ON) && (rf_wr == byp_rs2) && (byp_rs2 != 5'd0);
      byp_data1 = rf_wd;
      byp_data2 = rf_wd;
   end
`endif

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Testbench for reg_writeback_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the write-back rules.
// Bypass checks are included when WB_BYPASS_EN is defined.

`ifndef REGWE_WRITE
`define REGWE_WRITE 1'b1
`endif

module tb_reg_writeback_arbiter;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam logic WE_ON  = `REGWE_WRITE;
   localparam logic WE_OFF = ~`REGWE_WRITE;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            rf_we;
   logic [4:0]      rf_wr;
   logic [XLEN-1:0] rf_wd;
   logic [31:0]     pending;
`ifdef WB_BYPASS_EN
   logic [4:0]      byp_rs1;
   logic [4:0]      byp_rs2;
   logic            byp_hit1;
   logic            byp_hit2;
   logic [XLEN-1:0] byp_data1;
   logic [XLEN-1:0] byp_data2;
`endif

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [5+XLEN-1:0] m_fifo[$];
   logic              m_we;
   logic [4:0]        m_wr;
   logic [XLEN-1:0]   m_wd;
   logic [31:0]       m_pending;

   // expected drain order for the full-FIFO scenario
   logic [5+XLEN-1:0] exp_q[$];

   reg_writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
`ifdef WB_BYPASS_EN
      .byp_rs1   (byp_rs1),
      .byp_rs2   (byp_rs2),
      .byp_hit1  (byp_hit1),
      .byp_hit2  (byp_hit2),
      .byp_data1 (byp_data1),
      .byp_data2 (byp_data2),
`endif
      .rf_we     (rf_we),
      .rf_wr     (rf_wr),
      .rf_wd     (rf_wd),
      .pending   (pending)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_fifo.delete();
      m_we      = 1'b0;
      m_wr      = 5'd0;
      m_wd      = '0;
      m_pending = '0;
   endtask

   // One clock of the write-back rules, applied to the inputs present at the edge.
   task automatic model_update();
      bit ready;
      bit loaded;
      ready  = (m_fifo.size() < DEPTH);
      loaded = 0;
      if (flush) begin
         m_fifo.delete();
         m_pending = '0;
         m_we      = 1'b0;
      end else begin
         if (alu_valid && alu_rd != 5'd0) begin
            m_we = 1'b1; m_wr = alu_rd; m_wd = alu_data; loaded = 1;
         end else if (m_fifo.size() > 0) begin
            {m_wr, m_wd} = m_fifo.pop_front();
            m_we = 1'b1; loaded = 1;
         end else begin
            m_we = 1'b0;
         end
         if (lsu_valid && ready && lsu_rd != 5'd0) m_fifo.push_back({lsu_rd, lsu_data});
         if (loaded) m_pending[m_wr] = 1'b0;
         if (iss_valid && iss_rd != 5'd0) m_pending[iss_rd] = 1'b1;
      end
   endtask

   // driver: advance one clock, update the model, then settle just past the edge
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; iss_valid = 0; iss_rd = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
`ifdef WB_BYPASS_EN
      byp_rs1 = 0; byp_rs2 = 0;
`endif
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      model_reset();
      #2;
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL reset_we: got %b want %b", rf_we, WE_OFF); end
      checks++; if (rf_wr !== 5'd0) begin errors++; $display("FAIL reset_wr: got %0d want 0", rf_wr); end
      checks++; if (rf_wd !== '0) begin errors++; $display("FAIL reset_wd: got %h want 0", rf_wd); end
      checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", lsu_ready); end
      @(negedge clk);
      rst_n = 1;
      tick();
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL reset_idle_we: got %b want %b", rf_we, WE_OFF); end
   endtask

   task automatic test_alu();
      iss_valid = 1; iss_rd = 5;
      tick();
      iss_valid = 0;
      checks++; if (pending[5] !== 1'b1) begin errors++; $display("FAIL alu_issue_pending: got %b want 1", pending[5]); end
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 0;
      checks++; if (rf_we !== WE_ON) begin errors++; $display("FAIL alu_we: got %b want %b", rf_we, WE_ON); end
      checks++; if (rf_wr !== 5'd5) begin errors++; $display("FAIL alu_wr: got %0d want 5", rf_wr); end
      checks++; if (rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wd: got %h want deadbeef", rf_wd); end
      checks++; if (pending[5] !== 1'b0) begin errors++; $display("FAIL alu_pending_clear: got %b want 0", pending[5]); end
      tick();
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL alu_one_shot: got %b want %b", rf_we, WE_OFF); end
   endtask

   task automatic test_conflict();
      alu_valid = 1; alu_rd = 3; alu_data = 32'h0000_3333;
      lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_0011;
      tick();
      idle_inputs();
      checks++; if (rf_we !== WE_ON || rf_wr !== 5'd3) begin errors++; $display("FAIL conflict_alu_first: got we=%b wr=%0d want we=%b wr=3", rf_we, rf_wr, WE_ON); end
      tick();
      checks++; if (rf_we !== WE_ON || rf_wr !== 5'd7 || rf_wd !== 32'h11) begin errors++; $display("FAIL conflict_lsu_second: got we=%b wr=%0d wd=%h want wr=7 wd=11", rf_we, rf_wr, rf_wd); end
      tick();
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL conflict_idle: got %b want %b", rf_we, WE_OFF); end
   endtask

   task automatic test_full();
      exp_q.delete();
      alu_valid = 1; alu_rd = 1;
      lsu_valid = 1;
      for (int i = 0; i <= DEPTH; i++) begin
         alu_data = $urandom;
         lsu_rd   = 5'(10 + i);
         lsu_data = $urandom;
         if (lsu_ready === 1'b1) exp_q.push_back({lsu_rd, lsu_data});
         tick();
         checks++;
         if (lsu_ready !== ((i + 1) < DEPTH)) begin
            errors++; $display("FAIL full_ready_%0d: got %b want %b", i, lsu_ready, ((i + 1) < DEPTH));
         end
      end
      checks++; if (exp_q.size() != DEPTH) begin errors++; $display("FAIL full_accepted: got %0d want %0d", exp_q.size(), DEPTH); end
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin
         logic [5+XLEN-1:0] e;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         tick();
         checks++;
         if (rf_we !== WE_ON || {rf_wr, rf_wd} !== e) begin
            errors++; $display("FAIL full_drain_%0d: got we=%b wr=%0d wd=%h want wr=%0d wd=%h", i, rf_we, rf_wr, rf_wd, e[5+XLEN-1:XLEN], e[XLEN-1:0]);
         end
      end
      tick();
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL full_drained: got %b want %b", rf_we, WE_OFF); end
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after: got %b want 1", lsu_ready); end
   endtask

   task automatic test_x0_scoreboard();
      alu_valid = 1; alu_rd = 0; alu_data = 32'hBAD0_0000;
      lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hBAD0_0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL x0_we_%0d: got %b want %b", i, rf_we, WE_OFF); end
      end
      idle_inputs();
      tick();
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL x0_not_queued: got %b want %b", rf_we, WE_OFF); end
      iss_valid = 1; iss_rd = 9;
      tick();
      alu_valid = 1; alu_rd = 9; alu_data = 32'h9999_0000;
      tick();
      idle_inputs();
      checks++; if (rf_we !== WE_ON || rf_wr !== 5'd9) begin errors++; $display("FAIL sb_write9: got we=%b wr=%0d want wr=9", rf_we, rf_wr); end
      checks++; if (pending[9] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", pending[9]); end
      tick();
      checks++; if (pending[9] !== 1'b1) begin errors++; $display("FAIL sb_still_pending: got %b want 1", pending[9]); end
      alu_valid = 1; alu_rd = 9; alu_data = 32'h9999_0001;
      tick();
      idle_inputs();
      checks++; if (pending[9] !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", pending[9]); end
      checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL sb_bit0: got %b want 0", pending[0]); end
   endtask

   task automatic test_flush();
      alu_valid = 1; alu_rd = 1;
      lsu_valid = 1;
      iss_valid = 1;
      for (int i = 0; i < 3; i++) begin
         alu_data = $urandom;
         lsu_rd   = 5'(20 + i);
         lsu_data = $urandom;
         iss_rd   = (i == 0) ? 5'd4 : (i == 1) ? 5'd7 : 5'd9;
         tick();
      end
      checks++; if (pending !== 32'h0000_0290) begin errors++; $display("FAIL flush_pre_pending: got %h want 00000290", pending); end
      checks++; if (rf_we !== WE_ON) begin errors++; $display("FAIL flush_pre_we: got %b want %b", rf_we, WE_ON); end
      flush = 1;
      alu_rd = 2; iss_rd = 5; lsu_rd = 23;
      tick();
      idle_inputs();
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL flush_we: got %b want %b", rf_we, WE_OFF); end
      checks++; if (pending !== 32'd0) begin errors++; $display("FAIL flush_pending: got %h want 0", pending); end
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", lsu_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL flush_no_write_%0d: got %b want %b", i, rf_we, WE_OFF); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         flush     = ($urandom_range(0, 39) == 0);
         iss_valid = $urandom_range(0, 1);
         iss_rd    = 5'($urandom_range(0, 31));
         alu_valid = ($urandom_range(0, 2) == 0);
         alu_rd    = 5'($urandom_range(0, 31));
         alu_data  = $urandom;
         lsu_valid = $urandom_range(0, 1);
         lsu_rd    = 5'($urandom_range(0, 31));
         lsu_data  = $urandom;
         tick();
         checks++;
         if (rf_we !== (m_we ? WE_ON : WE_OFF) || rf_wr !== m_wr || rf_wd !== m_wd) begin
            errors++; $display("FAIL rand_port_c%0d: got we=%b wr=%0d wd=%h want we=%b wr=%0d wd=%h", c, rf_we, rf_wr, rf_wd, m_we ? WE_ON : WE_OFF, m_wr, m_wd);
         end
         checks++;
         if (pending !== m_pending) begin
            errors++; $display("FAIL rand_pending_c%0d: got %h want %h", c, pending, m_pending);
         end
         checks++;
         if (lsu_ready !== (m_fifo.size() < DEPTH)) begin
            errors++; $display("FAIL rand_ready_c%0d: got %b want %b", c, lsu_ready, (m_fifo.size() < DEPTH));
         end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
      lsu_valid = 1; lsu_rd = 12; lsu_data = 32'h1200;
      iss_valid = 1; iss_rd = 12;
      tick();
      tick();
      #2;
      rst_n = 0;
      #1;
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL areset_we: got %b want %b", rf_we, WE_OFF); end
      checks++; if (pending !== 32'd0) begin errors++; $display("FAIL areset_pending: got %h want 0", pending); end
      checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b want 1", lsu_ready); end
      checks++; if (rf_wr !== 5'd0 || rf_wd !== '0) begin errors++; $display("FAIL areset_addr_data: got wr=%0d wd=%h want 0", rf_wr, rf_wd); end
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1;
      tick();
      checks++; if (rf_we !== WE_OFF) begin errors++; $display("FAIL areset_queue_lost: got %b want %b", rf_we, WE_OFF); end
   endtask

`ifdef WB_BYPASS_EN
   task automatic test_bypass();
      alu_valid = 1; alu_rd = 4; alu_data = 32'hCAFE_0004;
      tick();
      idle_inputs();
      byp_rs1 = 4; byp_rs2 = 0;
      #1;
      checks++; if (byp_hit1 !== 1'b1) begin errors++; $display("FAIL byp_hit1: got %b want 1", byp_hit1); end
      checks++; if (byp_data1 !== 32'hCAFE_0004) begin errors++; $display("FAIL byp_data1: got %h want cafe0004", byp_data1); end
      checks++; if (byp_hit2 !== 1'b0) begin errors++; $display("FAIL byp_hit2: got %b want 0", byp_hit2); end
      tick();
      checks++; if (byp_hit1 !== 1'b0) begin errors++; $display("FAIL byp_hit1_idle: got %b want 0", byp_hit1); end
      byp_rs1 = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_conflict();
      test_full();
      test_x0_scoreboard();
      test_flush();
      test_random();
`ifdef WB_BYPASS_EN
      test_bypass();
`endif
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
